// File: rtl/cnn_layer_mem_chk.sv
// Multi-bank CNN layer memory with an expected-image array and a self-check sweeper
// that counts per-bank tolerance mismatches and latches the first failing location.
module cnn_layer_mem_chk #(
  parameter int unsigned DW     = 20,
  parameter int unsigned AW     = 12,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned NBANK  = 5,
  parameter int unsigned CSW    = 3,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned TOL    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cwr,
  input  logic [AW-1:0]          caddr_wr,
  input  logic [DW-1:0]          cdata_wr,
  input  logic                   crd,
  input  logic [AW-1:0]          caddr_rd,
  input  logic [CSW-1:0]         csel,
  output logic [DW-1:0]          cdata_rd,
  input  logic                   exp_we,
  input  logic [CSW-1:0]         exp_sel,
  input  logic [AW-1:0]          exp_addr,
  input  logic [DW-1:0]          exp_data,
  input  logic                   chk_start,
  output logic                   chk_busy,
  output logic                   chk_done,
  output logic [NBANK-1:0]       written,
  output logic [NBANK*(AW+1)-1:0] err_cnt,
  output logic                   err_any,
  output logic [CSW-1:0]         first_err_bank,
  output logic [AW-1:0]          first_err_addr
);

  localparam int unsigned BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int unsigned LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  logic [DW-1:0] mem_q     [NBANK][DEPTH];
  logic [DW-1:0] exp_mem_q [NBANK][DEPTH];

  state_e            state_q;
  logic              busy_q, done_q, issue_done_q;
  logic [BW-1:0]     bank_q, cmp_bank_q;
  logic [LW-1:0]     addr_q, cmp_addr_q;
  logic              cmp_v_q;
  logic [DW-1:0]     dut_q, exp_q;
  logic [AW:0]       err_cnt_q [NBANK];
  logic              err_any_q;
  logic [CSW-1:0]    first_bank_q;
  logic [AW-1:0]     first_addr_q;
  logic [NBANK-1:0]  written_q;
  logic [RD_LAT-1:0] rv_q;
  logic [DW-1:0]     rd_q [RD_LAT];
  logic [DW-1:0]     hold_q;

  logic          sel_ok, exp_sel_ok, wr_en, rd_en, exp_en, rd_in_range;
  logic [BW-1:0] sel_bank, exp_bank;
  logic [DW-1:0] rd_word, diff;
  logic [DW:0]   mag;
  logic          mismatch, last_word;

  always_comb begin
    sel_ok      = (csel != '0) && (csel <= CSW'(NBANK));
    exp_sel_ok  = (exp_sel != '0) && (exp_sel <= CSW'(NBANK));
    sel_bank    = BW'(csel - 1'b1);
    exp_bank    = BW'(exp_sel - 1'b1);
    // External traffic is locked out for the whole sweep
    wr_en       = cwr && sel_ok && ({1'b0, caddr_wr} < DepthW) && !busy_q;
    exp_en      = exp_we && exp_sel_ok && ({1'b0, exp_addr} < DepthW) && !busy_q;
    rd_en       = crd && sel_ok && !busy_q;
    rd_in_range = {1'b0, caddr_rd} < DepthW;
    rd_word     = rd_in_range ? mem_q[sel_bank][LW'(caddr_rd)] : '0;
    // Signed modular difference; magnitude kept one bit wider so -2**(DW-1) is exact
    diff        = dut_q - exp_q;
    mag         = diff[DW-1] ? ({1'b0, ~diff} + 1'b1) : {1'b0, diff};
    mismatch    = cmp_v_q && (mag > (DW+1)'(TOL));
    last_word   = !written_q[bank_q] || (addr_q == LW'(DEPTH-1));
  end

  always_ff @(posedge clk) begin
    if (wr_en)  mem_q[sel_bank][LW'(caddr_wr)]     <= cdata_wr;
    if (exp_en) exp_mem_q[exp_bank][LW'(exp_addr)] <= exp_data;
  end

  // Read pipeline: stage RD_LAT-1 drives cdata_rd, otherwise the last value is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_q   <= '0;
      hold_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_q[i] <= '0;
    end else begin
      rv_q[0] <= rd_en;
      rd_q[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_q[i] <= rv_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
      hold_q <= cdata_rd;
    end
  end

  assign cdata_rd = rv_q[RD_LAT-1] ? rd_q[RD_LAT-1] : hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      issue_done_q <= 1'b0;
      bank_q       <= '0;
      addr_q       <= '0;
      cmp_v_q      <= 1'b0;
      cmp_bank_q   <= '0;
      cmp_addr_q   <= '0;
      dut_q        <= '0;
      exp_q        <= '0;
      err_any_q    <= 1'b0;
      first_bank_q <= '0;
      first_addr_q <= '0;
      written_q    <= '0;
      for (int b = 0; b < NBANK; b++) err_cnt_q[b] <= '0;
    end else begin
      if (wr_en) written_q[sel_bank] <= 1'b1;
      cmp_v_q <= 1'b0;
      if (mismatch) begin
        err_cnt_q[cmp_bank_q] <= err_cnt_q[cmp_bank_q] + 1'b1;
        if (!err_any_q) begin
          err_any_q    <= 1'b1;
          first_bank_q <= CSW'(cmp_bank_q) + 1'b1;
          first_addr_q <= AW'(cmp_addr_q);
        end
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (chk_start) begin
            state_q      <= StSweep;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            issue_done_q <= 1'b0;
            bank_q       <= '0;
            addr_q       <= '0;
            err_any_q    <= 1'b0;
            first_bank_q <= '0;
            first_addr_q <= '0;
            for (int b = 0; b < NBANK; b++) err_cnt_q[b] <= '0;
          end
        end
        StSweep: begin
          if (issue_done_q) begin
            // Last compare retires on this edge
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            if (written_q[bank_q]) begin
              cmp_v_q    <= 1'b1;
              cmp_bank_q <= bank_q;
              cmp_addr_q <= addr_q;
              dut_q      <= mem_q[bank_q][addr_q];
              exp_q      <= exp_mem_q[bank_q][addr_q];
            end
            if (last_word) begin
              addr_q <= '0;
              if (bank_q == BW'(NBANK-1)) issue_done_q <= 1'b1;
              else                        bank_q       <= bank_q + 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_err
    assign err_cnt[b*(AW+1) +: AW+1] = err_cnt_q[b];
  end

  assign chk_busy       = busy_q;
  assign chk_done       = done_q;
  assign written        = written_q;
  assign err_any        = err_any_q;
  assign first_err_bank = first_bank_q;
  assign first_err_addr = first_addr_q;

endmodule

// File: doc/cnn_layer_mem_chk.md
Name: cnn_layer_mem_chk

Overview:
- Parametrised multi-bank layer memory with a built-in self-check sweeper for the CNN layer pipeline (conv, pool, flatten).
- Serves the CONV-style write/read port: cwr, caddr_wr, cdata_wr, crd, caddr_rd, cdata_rd, csel.
- Stores every layer's output and compares each written bank against an expected image.
- Comparison uses a programmable ±TOL tolerance, and the block reports per-bank error counts and the first failing location.

Parameters:
- DW, 20, data word width.
- AW, 12, address width.
- DEPTH, 4096, words per bank, ≤ 2**AW.
- NBANK, 5, number of banks; csel k (1..NBANK) maps to bank k-1.
- CSW, 3, csel width, ≥ clog2(NBANK+1).
- RD_LAT, 1, read latency in cycles, legal values 1..3.
- TOL, 0, allowed |dut-exp| per word.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cwr  in  1  write strobe.
- caddr_wr  in  AW  write address.
- cdata_wr  in  DW  write data.
- crd  in  1  read strobe.
- caddr_rd  in  AW  read address.
- csel  in  CSW  bank select; 0 and values > NBANK are invalid.
- cdata_rd  out  DW  read data.
- exp_we  in  1  expected-image write strobe.
- exp_sel  in  CSW  expected-image bank, same mapping as csel.
- exp_addr  in  AW  expected-image address.
- exp_data  in  DW  expected-image data.
- chk_start  in  1  single-cycle pulse that starts the sweep.
- chk_busy  out  1  high during the sweep.
- chk_done  out  1  level, high from sweep end until the next accepted chk_start or reset.
- written  out  NBANK  sticky flag per bank: at least one write received.
- err_cnt  out  NBANK*(AW+1)  per-bank mismatch counts; bank b occupies bits [b*(AW+1) +: AW+1].
- err_any  out  1  OR of all mismatches.
- first_err_bank  out  CSW  csel code of the first mismatch.
- first_err_addr  out  AW  address of the first mismatch.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0; FSM goes to IDLE; written, counters and first_err fields are cleared.
  - Memory and expected-image contents are retained and not initialised.
  - Reset asserted mid-sweep aborts the sweep immediately.
- Writes:
  - Taken on a rising edge when cwr=1, csel is valid and caddr_wr < DEPTH; the addressed bank word is written and written[csel-1] is set.
  - A write with invalid csel or out-of-range address is dropped and changes no flag.
  - exp_we follows the same rules into a separate expected array and does not affect written.
- Reads:
  - crd=1 with valid csel and in-range address returns data on cdata_rd exactly RD_LAT cycles later.
  - A read with in-range address but invalid csel leaves cdata_rd holding its previous value.
  - A read with valid csel but address ≥ DEPTH returns 0 after RD_LAT cycles.
  - Reads are fully pipelined, one per cycle.
  - cdata_rd holds between reads.
  - Same-cycle cwr and crd to the same bank and address returns the old data (read-before-write).
- FSM:
  - IDLE: on chk_start go to SWEEP; clear err_cnt, err_any and first_err; set chk_done=0.
  - SWEEP: chk_busy=1. Bank counter runs 0..NBANK-1 and address counter 0..DEPTH-1, one compare per cycle.
    - Banks with written=0 are skipped in one cycle; their err_cnt stays 0.
    - Compares are pipelined: each compare uses a one-cycle internal read and retires one cycle after its address is issued.
    - After the last compare retires, go to DONE.
    - Total sweep length is (written banks × DEPTH) + (unwritten banks) + 1 cycles.
  - DONE: chk_busy=0, chk_done=1. chk_start restarts the sweep (back to SWEEP, counters cleared).
  - chk_start while in SWEEP is ignored.
- Access during SWEEP: external cwr, crd and exp_we are dropped, and cdata_rd holds its value.
- Compare rule:
  - d = (dut - exp) mod 2**DW, interpreted as signed DW-bit; a mismatch is |d| > TOL.
  - Wrap-around is intentional: with DW=20, dut=0x00000 and exp=0xFFFFF give d=+1.
  - On a mismatch, err_cnt[bank] increments. Its AW+1 bits hold up to DEPTH, so it never overflows.
  - The first mismatch of a sweep latches first_err_bank (csel code) and first_err_addr and sets err_any.

Test Plan:
- Write bank1 addr0..4095 with data=addr, load expected identically, pulse chk_start → chk_busy lasts 4096+4+1 cycles; chk_done=1; err_cnt all 0; err_any=0; written=5'b00001.
- Same as above, but corrupt bank3 addr 100 (dut 0x00064 vs exp 0x00065) with TOL=0 → err_cnt[bank2]=1, first_err_bank=3, first_err_addr=100. With TOL=1 → no error.
- dut=0x00000, exp=0xFFFFF, TOL=1 → no mismatch (wrap). dut=0x00000, exp=0xFFFFD, TOL=1 → mismatch.
- Read bank5 addr 7 with RD_LAT=2 (cwr to bank5 addr 7 in the same cycle) → old data appears 2 cycles later. A read with csel=6 holds cdata_rd. A write with csel=0 leaves written unchanged.
- Assert reset mid-sweep at cycle 1000 → outputs 0, FSM IDLE. Re-check after reset → written=0, so every bank is skipped and DONE is reached in NBANK+1 cycles.
- chk_start pulsed again during SWEEP → ignored, counts unchanged. chk_start in DONE → counters cleared, new sweep runs.
